// File: rtl/epl_accumulator_if.sv
// epl_accumulator_if: sample/chip inputs and latched correlation results of one tracking channel
interface epl_accumulator_if #(
  parameter int IN_W  = 3,
  parameter int ACC_W = 16
);
  logic acc_clear, sample_enable, early, prompt, late, dump_enable, read_ack;
  logic signed [IN_W-1:0] i_sample, q_sample;
  logic signed [ACC_W-1:0] i_early, q_early, i_prompt, q_prompt, i_late, q_late;
  logic accum_valid, overrun, saturated;
  logic [7:0] dump_count;
  modport master (
    output acc_clear, sample_enable, i_sample, q_sample, early, prompt, late, dump_enable, read_ack,
    input  i_early, q_early, i_prompt, q_prompt, i_late, q_late, accum_valid, overrun, saturated, dump_count
  );
  modport slave (
    input  acc_clear, sample_enable, i_sample, q_sample, early, prompt, late, dump_enable, read_ack,
    output i_early, q_early, i_prompt, q_prompt, i_late, q_late, accum_valid, overrun, saturated, dump_count
  );
endinterface

// File: rtl/epl_accumulator.sv
// epl_accumulator: early/prompt/late I/Q correlator with saturating integrate-and-dump
module epl_accumulator #(
  parameter int IN_W  = 3,
  parameter int ACC_W = 16
) (
  input logic clk,
  input logic rst,
  epl_accumulator_if.slave bus
);
  localparam logic [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};
  logic signed [ACC_W-1:0] acc_q [6];
  logic signed [ACC_W-1:0] acc_d [6];
  logic signed [ACC_W-1:0] out_q [6];
  logic signed [ACC_W-1:0] out_d [6];
  logic signed [ACC_W-1:0] ext [6];
  logic signed [ACC_W-1:0] prod [6];
  logic signed [ACC_W-1:0] sum [6];
  logic [5:0] clip;
  logic [2:0] chips;
  logic sat_q, sat_d, valid_q, valid_d, overrun_q, overrun_d, saturated_q, saturated_d;
  logic [7:0] count_q, count_d;
  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a, input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    return (s[ACC_W] != s[ACC_W-1]) ? {1'b1, s[ACC_W] ? MIN_V : MAX_V} : {1'b0, s[ACC_W-1:0]};
  endfunction
  assign chips = {bus.late, bus.prompt, bus.early};
  // Arms ordered i_early, q_early, i_prompt, q_prompt, i_late, q_late; chip 0 negates the widened sample
  for (genvar g = 0; g < 6; g++) begin : arm
    assign ext[g] = ACC_W'((g % 2 == 1) ? bus.q_sample : bus.i_sample);
    assign prod[g] = chips[g/2] ? ext[g] : -ext[g];
    assign {clip[g], sum[g]} = bus.sample_enable ? sat_add(acc_q[g], prod[g]) : {1'b0, acc_q[g]};
  end
  // Next state: clear beats dump beats plain accumulate; ack always refers to the data already latched
  always_comb begin
    acc_d = acc_q;
    out_d = out_q;
    sat_d = sat_q;
    valid_d = valid_q;
    overrun_d = overrun_q;
    saturated_d = saturated_q;
    count_d = count_q;
    if (bus.acc_clear) begin
      acc_d = '{default: '0};
      sat_d = 1'b0;
      valid_d = 1'b0;
      overrun_d = 1'b0;
      saturated_d = 1'b0;
      count_d = 8'd0;
    end else begin
      if (bus.dump_enable) begin
        out_d = sum;
        saturated_d = sat_q | (|clip);
        acc_d = '{default: '0};
        sat_d = 1'b0;
        count_d = count_q + 8'd1;
      end else begin
        acc_d = sum;
        sat_d = sat_q | (|clip);
      end
      valid_d = bus.dump_enable | (valid_q & ~bus.read_ack);
      overrun_d = (bus.read_ack & valid_q) ? 1'b0 : overrun_q | (bus.dump_enable & valid_q);
    end
  end
  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '{default: '0};
      out_q <= '{default: '0};
      sat_q <= 1'b0;
      valid_q <= 1'b0;
      overrun_q <= 1'b0;
      saturated_q <= 1'b0;
      count_q <= 8'd0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
      sat_q <= sat_d;
      valid_q <= valid_d;
      overrun_q <= overrun_d;
      saturated_q <= saturated_d;
      count_q <= count_d;
    end
  end
  assign bus.i_early = out_q[0];
  assign bus.q_early = out_q[1];
  assign bus.i_prompt = out_q[2];
  assign bus.q_prompt = out_q[3];
  assign bus.i_late = out_q[4];
  assign bus.q_late = out_q[5];
  assign bus.accum_valid = valid_q;
  assign bus.overrun = overrun_q;
  assign bus.saturated = saturated_q;
  assign bus.dump_count = count_q;
endmodule

// File: doc/epl_accumulator.md
Name: epl_accumulator

Overview:
- Downstream of the code generator in each tracking channel.
- Correlates carrier-wiped I/Q samples against the half-chip-spaced early, prompt and late code chips from the code generator.
- Integrates the six products over one code period and latches them on the code generator's dump pulse.
- Exposes the latched results with a new-data/acknowledge handshake, overrun detection and saturation reporting.

Parameters:
IN_W, 3, width of signed two's-complement i_sample/q_sample
ACC_W, 16, width of each signed accumulator and output register

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
acc_clear  in  1  pulse: restart accumulation and clear all flags (asserted with PRN change)
sample_enable  in  1  one pulse per valid input sample
i_sample  in  IN_W  signed in-phase sample after carrier wipe-off
q_sample  in  IN_W  signed quadrature sample after carrier wipe-off
early  in  1  early chip
prompt  in  1  prompt chip
late  in  1  late chip
dump_enable  in  1  end-of-code-period pulse
read_ack  in  1  pulse: processor has read the latched results
i_early, q_early, i_prompt, q_prompt, i_late, q_late  out  ACC_W each  latched signed correlation sums
accum_valid  out  1  new latched data available
overrun  out  1  sticky: results overwritten before acknowledge
saturated  out  1  at least one latched sum clipped during the latched period
dump_count  out  8  number of dumps since rst/acc_clear, wraps 255->0

Behaviour:
- Reset (rst=1, synchronous): all accumulators 0, all six outputs 0, accum_valid=0, overrun=0, saturated=0, dump_count=0. rst overrides every other input.
- Chip mapping: chip=1 means +1, chip=0 means -1.
- Product: the sample is sign-extended to ACC_W, then negated when the chip is 0. Negating the most negative IN_W value is exact; there is no wrap.
- Accumulate: on sample_enable, each of the six accumulators adds its product. Saturating add clips to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)). Each clip sets an internal per-period sat bit.
- Without sample_enable the accumulators hold.
- Dump, effective the cycle after dump_enable:
  - Each output register <= accumulator plus the product of the current cycle if sample_enable is coincident (also saturating).
  - saturated <= OR of the period's sat bits, including the coincident add.
  - Accumulators and sat bits <= 0. The coincident sample belongs to the closing period.
  - dump_count increments.
- Latency: outputs and accum_valid update 1 clk after the dump_enable edge.
- Handshake:
  - accum_valid sets on dump and clears on read_ack.
  - If dump_enable arrives while accum_valid=1 and read_ack is not coincident, overrun <= 1 and the outputs are still overwritten.
  - dump_enable and read_ack in the same cycle: the ack applies to the old data, accum_valid stays 1, overrun is not set.
  - read_ack with accum_valid=0: no effect.
  - read_ack also clears overrun.
- acc_clear has priority over dump_enable, sample_enable and read_ack.
  - Clears accumulators, sat bits, accum_valid, overrun, saturated and dump_count.
  - Output registers hold their last values.
  - A sample or dump coincident with acc_clear is discarded.
- dump_enable without any prior sample_enable latches zeros, sets accum_valid, and increments dump_count.

Test Plan:
- Basic correlation: 10 samples i=+3, q=-2, early=1, prompt=1, late=0, then dump -> i_early=30, q_early=-20, i_prompt=30, q_prompt=-20, i_late=-30, q_late=20, accum_valid=1 one cycle after dump, dump_count=1.
- Coincident sample/dump: 5 samples i=+1 with prompt=1, then a 6th sample coincident with dump_enable -> i_prompt=6. Next period 3 samples i=+1 -> i_prompt=3, showing the accumulator restarted at 0.
- Overrun and ack rules:
  - Two dumps without read_ack -> overrun=1, outputs hold the second period's values.
  - read_ack -> accum_valid=0, overrun=0.
  - Dump and read_ack in the same cycle -> accum_valid=1, overrun=0.
- Saturation (ACC_W=8): 50 samples i=+3, early=1 -> i_early=127, saturated=1. Same setup with late=0 -> i_late=-128. The next unsaturated period clears saturated to 0.
- Sign edge: i=-4 (IN_W=3) with prompt=0 for 4 samples -> i_prompt=+16, with no wrap.
- Clear and reset mid-period:
  - 3 samples, then acc_clear, then 2 samples i=+1, prompt=1, then dump -> i_prompt=2, dump_count=1.
  - rst mid-period -> all outputs 0 the next cycle.
